// File: rtl/pattern_match_timer.sv
// Reaction-timer pattern matcher. The switch bank is compared against a target latched at trial start.
// A match must be held for STABLE_CYCLES samples. The result is either a reaction time or a timeout.
`timescale 1ns/1ps

module pattern_match_timer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 32,
    parameter int TIMEOUT       = 50000000
) (
    input  logic             clk50M,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [WIDTH-1:0] target,
    input  logic             start,
    input  logic             mode,
    input  logic             clear,
    output logic             Match,
    output logic             match_pulse,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] react_cycles
);

    localparam int               STB_W       = $clog2(STABLE_CYCLES + 1);
    localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CYCLE  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLD,
        S_DONE,
        S_TIMEOUT
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sync1_q, sync2_q;
    logic [WIDTH-1:0]   target_q, target_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   elapsed_q, elapsed_d;
    logic [CNT_W-1:0]   cand_q, cand_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]   react_q, react_d;
    logic               pulse_q, pulse_d;

    logic eq;
    logic start_ok;
    logic qualify;
    logic timeout_hit;

    // Two-flop synchroniser for the asynchronous switch bank.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    // A zero target would trivially match in masked mode, so it never matches.
    always_comb begin
        if (target_q == '0) begin
            eq = 1'b0;
        end else if (mode_q) begin
            eq = ((sync2_q & target_q) == target_q);
        end else begin
            eq = (sync2_q == target_q);
        end
    end

    assign start_ok    = start && (target != '0) &&
                         (state_q == S_IDLE || state_q == S_DONE || state_q == S_TIMEOUT);
    assign timeout_hit = (elapsed_q == LAST_CYCLE);
    assign qualify     = eq && (((state_q == S_ARMED) && (STABLE_CYCLES == 1)) ||
                                ((state_q == S_HOLD) && (stable_q == STABLE_LAST)));

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            mode_q    <= 1'b0;
            elapsed_q <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            react_q   <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            mode_q    <= mode_d;
            elapsed_q <= elapsed_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            react_q   <= react_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        target_d  = target_q;
        mode_d    = mode_q;
        elapsed_d = elapsed_q;
        cand_d    = cand_q;
        stable_d  = stable_q;
        react_d   = react_q;
        pulse_d   = 1'b0;

        if (clear) begin
            state_d   = S_IDLE;
            elapsed_d = '0;
            stable_d  = '0;
            react_d   = '0;
        end else if (start_ok) begin
            state_d   = S_ARMED;
            target_d  = target;
            mode_d    = mode;
            elapsed_d = '0;
            stable_d  = '0;
            react_d   = '0;
        end else begin
            case (state_q)
                S_ARMED, S_HOLD: begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                    if (qualify) begin
                        // Qualification beats a coincident timeout.
                        state_d = S_DONE;
                        pulse_d = 1'b1;
                        react_d = (state_q == S_ARMED) ? elapsed_q : cand_q;
                    end else if (timeout_hit) begin
                        state_d = S_TIMEOUT;
                    end else if (state_q == S_ARMED) begin
                        if (eq) begin
                            state_d  = S_HOLD;
                            cand_d   = elapsed_q;
                            stable_d = STB_W'(1);
                        end
                    end else if (eq) begin
                        stable_d = stable_q + STB_W'(1);
                    end else begin
                        state_d  = S_ARMED;
                        stable_d = '0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign Match        = (state_q == S_DONE);
    assign timeout      = (state_q == S_TIMEOUT);
    assign busy         = (state_q == S_ARMED) || (state_q == S_HOLD);
    assign match_pulse  = pulse_q;
    assign react_cycles = react_q;

endmodule
